uart_stream_ctrl: RTL and testbench
===================================

# uart_stream_ctrl

Sequencing controller between the UART receiver and the UART transmitter in the capitalizer datapath. It accepts received bytes from the receiver's one-cycle valid strobe, optionally upper-cases ASCII letters, buffers them in a small FIFO, and feeds the transmitter one byte at a time through a start/busy handshake. Overflow and handshake timeouts are reported through sticky flags.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2 to 16.
- TIMEOUT, 16: cycles allowed after o_tx_start for i_tx_busy to rise; 1 to 255.

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte, valid with i_rx_valid.
- i_rx_valid  in  1  one-cycle strobe from the receiver.
- i_cap_en  in  1  1 means map 'a'..'z' to 'A'..'Z'.
- i_tx_busy  in  1  transmitter busy, high from accepted start until the stop bit ends.
- i_clr_flags  in  1  one-cycle pulse that clears o_overflow and o_timeout.
- o_tx_data  out  8  byte presented to the transmitter; held stable from start until return to IDLE.
- o_tx_start  out  1  one-cycle start pulse.
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- o_overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- o_timeout  out  1  sticky: the transmitter never raised busy.

## Operation
- Transform on push: if i_cap_en=1 and 0x61 ≤ i_rx_data ≤ 0x7A, the stored value is i_rx_data − 0x20. Otherwise the byte is stored unchanged. i_cap_en is sampled in the same cycle as i_rx_valid.
- Push: i_rx_valid=1 writes the transformed byte at the edge that ends that cycle.
- Full FIFO: a push is dropped and o_overflow is set.
  - Exception: a push is accepted when the FIFO is full and a pop occurs in the same cycle.
- FSM states (2-bit): IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE → WAIT_BUSY when the FIFO is non-empty and i_tx_busy=0. On that edge: pop the head, load it into o_tx_data, drive o_tx_start=1 for the following cycle only, and clear the timeout counter.
  - WAIT_BUSY → WAIT_DONE when i_tx_busy=1.
  - WAIT_BUSY → IDLE when the counter reaches TIMEOUT with busy still low. On that edge o_timeout is set; the byte is considered sent and is not retried.
  - WAIT_DONE → IDLE when i_tx_busy=0.
- Flags: i_clr_flags clears both sticky flags. If a set event occurs in the same cycle as i_clr_flags, the set wins.
- o_level: increments on push, decrements on pop, and is unchanged on a simultaneous push and pop. It wraps at no point.
- Counter: 8-bit, saturating; it runs only in WAIT_BUSY.

## Timing
- Reset (i_rst_n=0, asynchronous) forces:
  - FSM to IDLE;
  - FIFO empty, with read and write pointers at 0;
  - o_tx_data=0x00, o_tx_start=0, o_level=0, o_overflow=0, o_timeout=0.
- Reset mid-transfer discards all FIFO contents and the in-flight byte. The first cycle after deassertion is IDLE.
- Latency with an empty FIFO, FSM in IDLE and busy low:
  - i_rx_valid in cycle 0;
  - entry written at edge 1;
  - IDLE detects non-empty in cycle 1;
  - o_tx_start=1 in cycle 2.
- Back-to-back: the next start comes no earlier than 1 cycle after i_tx_busy falls. There is never more than one start per busy episode.
- o_tx_start never asserts while i_tx_busy=1 or outside the IDLE→WAIT_BUSY transition.
- Timeout: with i_tx_busy held low after start, o_timeout rises TIMEOUT+1 cycles after the o_tx_start cycle.

## Structure
- Shared package uart_pkg holds:
  - the ASCII_LC_A (0x61), ASCII_LC_Z (0x7A) and CASE_OFFSET (0x20) constants;
  - the FSM state enum, ST_IDLE/ST_WAIT_BUSY/ST_WAIT_DONE.
- One sub-module, byte_fifo: a synchronous DEPTH×8 FIFO with push, pop, full, empty and level outputs, and extra-MSB pointers for full/empty. It is instantiated once.
- Transform logic and the FSM stay in uart_stream_ctrl.

## Test plan
- Capitalize: i_cap_en=1, push 0x61, 0x7A, 0x41, 0x7B. Required: starts carry 0x41, 0x5A, 0x41, 0x7B in order. With i_cap_en=0, 0x61 passes as 0x61.
- Latency/handshake: single push of 0x68 while idle gives o_tx_start in cycle 2 with o_tx_data=0x68. With busy modelled high for 10 cycles from cycle 3, exactly one start is seen and o_level returns to 0.
- Overflow: DEPTH=4, busy held high, push 5 bytes. Required: o_level=4, o_overflow=1, and the 5th byte is absent from the output stream. i_clr_flags then gives o_overflow=0.
- Timeout: push 0x55 with the transmitter model never raising busy. Required: o_timeout=1 exactly TIMEOUT+1 cycles after the start, FSM back in IDLE, and the next byte is started.
- Simultaneous events: with the FIFO full, a push in the same cycle as the IDLE pop is accepted, and o_level stays 4. i_clr_flags in the same cycle as an overflow leaves o_overflow=1.
- Reset mid-operation: assert i_rst_n=0 in WAIT_DONE with 3 entries queued. Required: all outputs zero, o_level=0, and no start after release until a new push arrives.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART capitalizer datapath.
//   ASCII_LC_A / ASCII_LC_Z : inclusive range of lower-case ASCII letters
//   CASE_OFFSET             : distance from lower to upper case
//   state_e                 : stream controller FSM states
package uart_pkg;

  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_Z  = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous DEPTH x 8 first-word-fall-through FIFO.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (pointers only)
//   i_push, i_data : write strobe and byte
//   i_pop          : read strobe; o_data shows the head while non-empty
//   o_full/o_empty : occupancy status
//   o_level        : number of stored entries (0..DEPTH)
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign o_level = wptr - rptr;
  assign o_data  = mem[rptr[AW-1:0]];

  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; contents are only visible through valid pointers.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_stream_ctrl.sv
// uart_stream_ctrl: sequences bytes from the UART receiver to the transmitter.
// Received bytes are optionally upper-cased, queued in byte_fifo, and handed
// to the transmitter one at a time with a start/busy handshake.
// Ports:
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_rx_data, i_rx_valid : received byte and its one-cycle strobe
//   i_cap_en              : map 'a'..'z' to 'A'..'Z' on push
//   i_tx_busy             : transmitter busy
//   i_clr_flags           : clears the sticky flags (a same-cycle set wins)
//   o_tx_data, o_tx_start : byte to send and its one-cycle start pulse
//   o_level               : FIFO occupancy
//   o_overflow, o_timeout : sticky error flags
module uart_stream_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  input  logic                     i_cap_en,
  input  logic                     i_tx_busy,
  input  logic                     i_clr_flags,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_start,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic                     o_timeout
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_e     state;
  state_e     state_nxt;
  logic [7:0] cnt;
  logic [7:0] push_data;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       pop;
  logic       drop;
  logic       to_set;

  function automatic logic [7:0] cap_byte(input logic [7:0] b, input logic en);
    if (en && (b >= ASCII_LC_A) && (b <= ASCII_LC_Z)) return b - CASE_OFFSET;
    return b;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign push_data = cap_byte(i_rx_data, i_cap_en);

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_rx_valid),
    .i_data  (push_data),
    .i_pop   (pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  // A push into a full FIFO survives only if the head leaves in the same cycle.
  assign drop = i_rx_valid && fifo_full && !pop;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    to_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !i_tx_busy) begin
          state_nxt = ST_WAIT_BUSY;
          pop       = 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_nxt = ST_WAIT_DONE;
        end else if (cnt == TO_LIMIT) begin
          // Byte is abandoned, not retried.
          state_nxt = ST_IDLE;
          to_set    = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake register stage: state, start pulse, held byte, timeout counter, flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_overflow <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_tx_start <= pop;
      if (pop) begin
        o_tx_data <= fifo_head;
        cnt       <= '0;
      end else if (state == ST_WAIT_BUSY) begin
        cnt <= sat_inc(cnt);
      end
      if (drop)             o_overflow <= 1'b1;
      else if (i_clr_flags) o_overflow <= 1'b0;
      if (to_set)           o_timeout  <= 1'b1;
      else if (i_clr_flags) o_timeout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_stream_ctrl.sv
module tb_uart_stream_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic                   i_clk       = 1'b0;
  logic                   i_rst_n     = 1'b0;
  logic [7:0]             i_rx_data   = 8'h00;
  logic                   i_rx_valid  = 1'b0;
  logic                   i_cap_en    = 1'b0;
  logic                   i_tx_busy;
  logic                   i_clr_flags = 1'b0;
  logic [7:0]             o_tx_data;
  logic                   o_tx_start;
  logic [$clog2(DEPTH):0] o_level;
  logic                   o_overflow;
  logic                   o_timeout;

  int         checks = 0;
  int         errors = 0;
  int         starts = 0;
  int         s0;
  logic [7:0] sb [$];
  logic [7:0] exp_b;

  // Transmitter model
  logic hold_busy  = 1'b0;
  logic never_busy = 1'b0;
  int   busy_len   = 3;
  logic busy_r;
  int   busy_cnt;

  assign i_tx_busy = hold_busy | busy_r;

  uart_stream_ctrl #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .i_cap_en    (i_cap_en),
    .i_tx_busy   (i_tx_busy),
    .i_clr_flags (i_clr_flags),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_level     (o_level),
    .o_overflow  (o_overflow),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xform(input logic [7:0] d, input logic cap);
    return (cap && d >= 8'h61 && d <= 8'h7A) ? d - 8'h20 : d;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic cap, input logic keep);
    i_rx_data  = d;
    i_cap_en   = cap;
    i_rx_valid = 1'b1;
    if (keep) sb.push_back(xform(d, cap));
    tick(1);
    i_rx_valid = 1'b0;
    i_cap_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (n < max && !(sb.size() == 0 && o_level == 0 && !i_tx_busy && !o_tx_start)) begin
      tick(1);
      n++;
    end
    tick(2);
    chk("drain_done", (n < max), 1);
  endtask

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_r   <= 1'b0;
      busy_cnt <= 0;
    end else if (o_tx_start && !never_busy) begin
      busy_r   <= 1'b1;
      busy_cnt <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      busy_r   <= 1'b0;
      busy_cnt <= 0;
    end
  end

  // Scoreboard consumer: every start must match the oldest expected byte.
  always @(negedge i_clk) begin
    if (i_rst_n && o_tx_start) begin
      starts++;
      chk("start_busy_low", i_tx_busy, 0);
      chk("start_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_b = sb.pop_front();
        chk("tx_data", o_tx_data, exp_b);
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_tx_start", o_tx_start, 0);
    chk("rst_level", o_level, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_timeout", o_timeout, 0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    tick(2);

    // Latency and single handshake
    busy_len = 10;
    s0 = starts;
    push(8'h68, 1'b0, 1'b1);
    chk("lat_c1_start", o_tx_start, 0);
    chk("lat_c1_level", o_level, 1);
    tick(1);
    chk("lat_c2_start", o_tx_start, 1);
    chk("lat_c2_data", o_tx_data, 8'h68);
    chk("lat_c2_level", o_level, 0);
    wait_idle(100);
    chk("lat_one_start", starts - s0, 1);
    chk("lat_level_end", o_level, 0);

    // Capitalize
    busy_len = 3;
    push(8'h61, 1'b1, 1'b1);
    push(8'h7A, 1'b1, 1'b1);
    push(8'h41, 1'b1, 1'b1);
    push(8'h7B, 1'b1, 1'b1);
    push(8'h61, 1'b0, 1'b1);
    wait_idle(200);
    chk("cap_no_overflow", o_overflow, 0);

    // Overflow with busy held high
    hold_busy = 1'b1;
    s0 = starts;
    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i), 1'b0, 1'b1);
    push(8'h35, 1'b0, 1'b0);
    chk("ovf_level", o_level, 4);
    chk("ovf_flag", o_overflow, 1);
    i_clr_flags = 1'b1;
    tick(1);
    i_clr_flags = 1'b0;
    chk("ovf_cleared", o_overflow, 0);
    chk("ovf_level_hold", o_level, 4);
    chk("ovf_no_start", starts - s0, 0);

    // Push while full in the same cycle as the IDLE pop
    hold_busy = 1'b0;
    push(8'h36, 1'b0, 1'b1);
    chk("simul_start", o_tx_start, 1);
    chk("simul_level", o_level, 4);
    chk("simul_no_ovf", o_overflow, 0);
    tick(1);
    // Overflow and clear in the same cycle: set wins
    hold_busy   = 1'b1;
    i_clr_flags = 1'b1;
    push(8'h37, 1'b0, 1'b0);
    i_clr_flags = 1'b0;
    chk("set_beats_clr", o_overflow, 1);
    chk("set_clr_level", o_level, 4);
    hold_busy = 1'b0;
    wait_idle(300);

    // Timeout
    i_clr_flags = 1'b1;
    tick(1);
    i_clr_flags = 1'b0;
    chk("to_clear_ovf", o_overflow, 0);
    never_busy = 1'b1;
    push(8'h55, 1'b0, 1'b1);
    push(8'h56, 1'b0, 1'b1);
    chk("to_start", o_tx_start, 1);
    chk("to_start_data", o_tx_data, 8'h55);
    tick(TIMEOUT);
    chk("to_not_yet", o_timeout, 0);
    tick(1);
    chk("to_rise", o_timeout, 1);
    chk("to_idle_gap", o_tx_start, 0);
    tick(1);
    chk("to_next_start", o_tx_start, 1);
    chk("to_next_data", o_tx_data, 8'h56);
    tick(TIMEOUT + 4);
    chk("to_sticky", o_timeout, 1);
    never_busy = 1'b0;
    wait_idle(100);
    i_clr_flags = 1'b1;
    tick(1);
    i_clr_flags = 1'b0;
    chk("to_cleared", o_timeout, 0);

    // Reset in WAIT_DONE with 3 entries queued
    busy_len = 10;
    push(8'h41, 1'b0, 1'b1);
    push(8'h42, 1'b0, 1'b1);
    push(8'h43, 1'b0, 1'b1);
    push(8'h44, 1'b0, 1'b1);
    tick(2);
    chk("pre_rst_level", o_level, 3);
    chk("pre_rst_busy", i_tx_busy, 1);
    i_rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_level", o_level, 0);
    chk("mid_rst_data", o_tx_data, 0);
    chk("mid_rst_start", o_tx_start, 0);
    chk("mid_rst_ovf", o_overflow, 0);
    chk("mid_rst_to", o_timeout, 0);
    tick(2);
    i_rst_n = 1'b1;
    s0 = starts;
    tick(20);
    chk("post_rst_no_start", starts - s0, 0);
    chk("post_rst_level", o_level, 0);
    push(8'h7A, 1'b1, 1'b1);
    wait_idle(100);
    chk("post_rst_one_start", starts - s0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
